// File: rtl/aes_pad_arbiter.sv
// Shares one AES-CTR pad generator among NUM_REQ requesters, one transaction in flight.
// Define AES_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
`timescale 1ns/1ps

module aes_pad_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ*96-1:0] req_nonce,
    input  logic [NUM_REQ*32-1:0] req_counter,
    input  logic [NUM_REQ-1:0]    req_val,
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic [127:0]          pad,
    output logic [NUM_REQ-1:0]    pad_val,
    input  logic [NUM_REQ-1:0]    pad_rdy,
    output logic [95:0]           aes_nonce,
    output logic [31:0]           aes_counter,
    output logic                  aes_req_val,
    input  logic                  aes_req_rdy,
    input  logic [127:0]          aes_pad,
    input  logic                  aes_pad_val,
    output logic                  aes_pad_rdy,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT_PAD} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] grant_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    int              idx;
    int              gid;

    // Search starts at rr_ptr; with rr_ptr tied to zero this is fixed priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_val[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

`ifdef AES_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == WAIT_PAD && aes_pad_val && pad_rdy[grant_id]) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            grant_id <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant_id;
        req_rdy     = '0;
        pad_val     = '0;
        aes_req_val = 1'b0;
        aes_pad_rdy = 1'b0;
        gid         = int'(grant_id);
        aes_nonce   = req_nonce[gid*96 +: 96];
        aes_counter = req_counter[gid*32 +: 32];
        case (state)
            ARB: begin
                if (found) begin
                    grant_next = winner;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                aes_req_val       = req_val[grant_id];
                req_rdy[grant_id] = aes_req_rdy;
                // A requester withdrawing before the handshake cancels without touching rr_ptr.
                if (!req_val[grant_id]) begin
                    state_next = ARB;
                end else if (aes_req_rdy) begin
                    state_next = WAIT_PAD;
                end
            end
            WAIT_PAD: begin
                pad_val[grant_id] = aes_pad_val;
                aes_pad_rdy       = pad_rdy[grant_id];
                if (aes_pad_val && pad_rdy[grant_id]) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    assign pad  = aes_pad;
    assign busy = (state != ARB);

endmodule
